// File: rtl/approx_mul_pipe.sv
`timescale 1ns/1ps
// approx_mul_pipe: 3-stage valid/ready unsigned multiplier. Each beat picks
// either the exact product or an approximate one. In the approximate result,
// every column below APPROX_COLS is the OR of its partial-product bits.
// Optional macro APPROX_MUL_STATS_EN adds saturating error statistics
// (stat_count / stat_err) and an exact-product side path.
module approx_mul_pipe #(
  parameter int WIDTH_A     = 8,
  parameter int WIDTH_B     = 8,
  parameter int APPROX_COLS = 4,
  parameter int STAT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         in_a,
  input  logic [WIDTH_B-1:0]         in_b,
  input  logic                       in_approx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] out_p,
  output logic                       out_approx
`ifdef APPROX_MUL_STATS_EN
  ,
  output logic [STAT_W-1:0]          stat_count,
  output logic [STAT_W-1:0]          stat_err
`endif
);

  localparam int PW = WIDTH_A + WIDTH_B;
  // Columns below APPROX_COLS belong to the OR-approximated low part.
  localparam logic [PW-1:0] LO_MASK = (PW'(1) << APPROX_COLS) - PW'(1);

  if (WIDTH_A < 2 || WIDTH_A > 32 || WIDTH_B < 2 || WIDTH_B > 32) begin : g_bad_width
    $error("approx_mul_pipe: operand widths must be 2..32");
  end
  if (APPROX_COLS < 0 || APPROX_COLS > PW - 1) begin : g_bad_cols
    $error("approx_mul_pipe: APPROX_COLS out of range");
  end
  if (STAT_W < 1) begin : g_bad_stat
    $error("approx_mul_pipe: STAT_W must be positive");
  end

  // Exact unsigned product at full output width.
  function automatic logic [PW-1:0] exact_mul(input logic [WIDTH_A-1:0] a,
                                              input logic [WIDTH_B-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // Weighted sum of the partial products in columns >= APPROX_COLS.
  function automatic logic [PW-1:0] approx_hi(input logic [WIDTH_A-1:0] a,
                                              input logic [WIDTH_B-1:0] b);
    logic [PW-1:0] acc;
    logic [PW-1:0] row;
    acc = '0;
    for (int i = 0; i < WIDTH_A; i++) begin
      row = (PW'(b) << i) & ~LO_MASK;
      if (((a >> i) & WIDTH_A'(1)) != '0) acc = acc + row;
    end
    return acc;
  endfunction

  // Per-column OR of the partial products below APPROX_COLS; no carries.
  function automatic logic [PW-1:0] approx_lo(input logic [WIDTH_A-1:0] a,
                                              input logic [WIDTH_B-1:0] b);
    logic [PW-1:0] l;
    l = '0;
    for (int i = 0; i < WIDTH_A; i++) begin
      for (int j = 0; j < WIDTH_B; j++) begin
        if ((i + j < APPROX_COLS) &&
            (((a >> i) & WIDTH_A'(1)) != '0) &&
            (((b >> j) & WIDTH_B'(1)) != '0))
          l = l | (PW'(1) << (i + j));
      end
    end
    return l;
  endfunction

  logic                stall;
  logic                vld_p0, vld_p1, vld_p2;
  logic [WIDTH_A-1:0]  a_p0;
  logic [WIDTH_B-1:0]  b_p0;
  logic                apx_p0, apx_p1;
  logic [PW-1:0]       hi_p1, lo_p1;

  // One global stall freezes every stage; bubbles are kept, never squeezed.
  assign stall     = vld_p2 & ~out_ready;
  assign in_ready  = rst | ~stall;
  assign out_valid = vld_p2;

  // Stage valid bits: cleared by reset, shift only when not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- S0: operand and mode capture ----
  always_ff @(posedge clk) begin
    if (!stall) begin
      a_p0   <= in_a;
      b_p0   <= in_b;
      apx_p0 <= in_approx;
    end
  end

  // ---- S1: high/low parts (exact product goes in hi with lo zero) ----
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (apx_p0) begin
        hi_p1 <= approx_hi(a_p0, b_p0);
        lo_p1 <= approx_lo(a_p0, b_p0);
      end else begin
        hi_p1 <= exact_mul(a_p0, b_p0);
        lo_p1 <= '0;
      end
      apx_p1 <= apx_p0;
    end
  end

  // ---- S2: final combine; L never carries into hi, so the add is exact ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p      <= '0;
      out_approx <= 1'b0;
    end else if (!stall) begin
      out_p      <= hi_p1 + lo_p1;
      out_approx <= apx_p1;
    end
  end

`ifdef APPROX_MUL_STATS_EN
  localparam int SUM_W = ((STAT_W > PW) ? STAT_W : PW) + 1;

  // Saturating accumulate: clamps at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] acc,
                                                input logic [PW-1:0]     inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(inc);
    if (s > SUM_W'({STAT_W{1'b1}})) return '1;
    return s[STAT_W-1:0];
  endfunction

  logic [PW-1:0] ex_p1, ex_p2;
  logic          stat_fire;

  assign stat_fire = vld_p2 & out_ready & out_approx;

  // Exact product travels in lockstep with S1/S2 for error measurement.
  always_ff @(posedge clk) begin
    if (!stall) begin
      ex_p1 <= exact_mul(a_p0, b_p0);
      ex_p2 <= ex_p1;
    end
  end

  // Count approximate results consumed and accumulate their shortfall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_count <= '0;
      stat_err   <= '0;
    end else if (stat_fire) begin
      stat_count <= sat_add(stat_count, PW'(1));
      stat_err   <= sat_add(stat_err, ex_p2 - out_p);
    end
  end
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
`timescale 1ns/1ps
// tb_approx_mul_pipe: random and directed stimulus; expected products come
// from a column-by-column model and are queued at input acceptance, and a
// negedge monitor pops them at each output handshake.
module tb_approx_mul_pipe;
  localparam int WA = 8;
  localparam int WB = 8;
  localparam int K  = 4;
  localparam int PW = WA + WB;

  logic clk, rst, in_valid, in_approx, out_ready;
  logic [WA-1:0] in_a;
  logic [WB-1:0] in_b;
  logic in_ready, out_valid, out_approx;
  logic [PW-1:0] out_p;
  logic in_ready0, out_valid0, out_approx0;
  logic [PW-1:0] out_p0;
`ifdef APPROX_MUL_STATS_EN
  logic [31:0] stat_count, stat_err, stat_count0, stat_err0;
  logic [3:0]  stat_count4, stat_err4;
  logic        in_ready4, out_valid4, out_approx4;
  logic [PW-1:0] out_p4;
  longint unsigned m_cnt, m_err, m_cnt4, m_err4;
`endif

  approx_mul_pipe #(.WIDTH_A(WA), .WIDTH_B(WB), .APPROX_COLS(K), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_approx(out_approx)
`ifdef APPROX_MUL_STATS_EN
    , .stat_count(stat_count), .stat_err(stat_err)
`endif
  );

  approx_mul_pipe #(.WIDTH_A(WA), .WIDTH_B(WB), .APPROX_COLS(0), .STAT_W(32)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid0), .out_ready(out_ready), .out_p(out_p0),
    .out_approx(out_approx0)
`ifdef APPROX_MUL_STATS_EN
    , .stat_count(stat_count0), .stat_err(stat_err0)
`endif
  );

`ifdef APPROX_MUL_STATS_EN
  approx_mul_pipe #(.WIDTH_A(WA), .WIDTH_B(WB), .APPROX_COLS(K), .STAT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid4), .out_ready(out_ready), .out_p(out_p4),
    .out_approx(out_approx4), .stat_count(stat_count4), .stat_err(stat_err4)
  );
`endif

  typedef struct {
    longint unsigned exp;
    longint unsigned exact;
    bit              apx;
    int              acc_edge;
    int              acc_stalls;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad = 0;
  int    edges = 0;
  int    stalls = 0;
  int    n_out = 0;
  bit    mon_en = 0;
  bit    held_v = 0;
  logic [PW-1:0] held_p;
  logic          held_x;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: walk every product column, count its set partial-product bits,
  // and either weight the count (high columns) or OR them into one bit.
  function automatic longint unsigned model(input longint unsigned a,
                                            input longint unsigned b,
                                            input bit apx, input int k);
    longint unsigned res = 0;
    int n;
    if (!apx) return a * b;
    for (int c = 0; c < PW; c++) begin
      n = 0;
      for (int i = 0; i < WA; i++) begin
        if (c - i >= 0 && c - i < WB && ((a >> i) & 1) == 1 && ((b >> (c - i)) & 1) == 1)
          n++;
      end
      if (c >= k) res += longint'(n) << c;
      else if (n > 0) res += 64'd1 << c;
    end
    return res;
  endfunction

  function automatic longint unsigned sat(input longint unsigned v,
                                          input longint unsigned inc, input int w);
    longint unsigned mx = (64'd1 << w) - 1;
    return (v + inc > mx) ? mx : v + inc;
  endfunction

  // Scoreboard push at acceptance; also counts edges and stall edges.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && !out_ready) stalls <= stalls + 1;
      if (in_valid && in_ready)
        q.push_back('{model(in_a, in_b, in_approx, K), model(in_a, in_b, 1'b0, K),
                      in_approx, edges + 1, stalls});
    end
    edges <= edges + 1;
  end

  // Monitor: handshake checks, hold stability, latency, statistics.
  always @(negedge clk) begin
    item_t it;
    if (mon_en) begin
      if (!rst) begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        chk("dut0_valid", out_valid0, out_valid);
        if (held_v && out_valid) begin
          chk("hold_p", out_p, held_p);
          chk("hold_x", out_approx, held_x);
        end
      end
`ifdef APPROX_MUL_STATS_EN
      chk("stat_count", stat_count, m_cnt);
      chk("stat_err", stat_err, m_err);
      chk("stat_count4", stat_count4, m_cnt4);
      chk("stat_err4", stat_err4, m_err4);
      chk("stat_err0", stat_err0, 0);
      chk("stat_count0", stat_count0, m_cnt);
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got out_p=%0d with no beat outstanding", out_p);
        end else begin
          it = q.pop_front();
          n_out++;
          chk("out_p", out_p, it.exp);
          chk("out_approx", out_approx, it.apx);
          chk("dut0_out_p", out_p0, it.exact);
          chk("latency", edges - it.acc_edge, 2 + (stalls - it.acc_stalls));
`ifdef APPROX_MUL_STATS_EN
          if (it.apx) begin
            m_cnt  = sat(m_cnt, 1, 32);
            m_err  = sat(m_err, it.exact - it.exp, 32);
            m_cnt4 = sat(m_cnt4, 1, 4);
            m_err4 = sat(m_err4, it.exact - it.exp, 4);
          end
`endif
        end
      end
      held_v = out_valid && !out_ready && !rst;
      held_p = out_p;
      held_x = out_approx;
`ifdef APPROX_MUL_STATS_EN
      if (rst) begin
        m_cnt = 0; m_err = 0; m_cnt4 = 0; m_err4 = 0;
      end
`endif
    end
  end

  task automatic cyc(input bit v, input logic [WA-1:0] a, input logic [WB-1:0] b, input bit m);
    in_valid = v; in_a = a; in_b = b; in_approx = m;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom % 8;
    if (r == 0) return 8'd0;
    if (r == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  initial begin
    int start_out;
    rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_approx = 0; out_ready = 1'b1;
`ifdef APPROX_MUL_STATS_EN
    m_cnt = 0; m_err = 0; m_cnt4 = 0; m_err4 = 0;
`endif
    chk("model_3x3_apx", model(3, 3, 1, K), 7);
    chk("model_ff_apx", model(255, 255, 1, K), 64991);
    @(posedge clk);
    mon_en = 1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_approx", out_approx, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed corner operands and back-to-back exact beats.
    cyc(1, 3, 3, 1);
    cyc(1, 3, 3, 0);
    cyc(1, 255, 255, 1);
    cyc(1, 255, 255, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 2, 3, 0);
    cyc(1, 15, 15, 0);
    repeat (5) cyc(0, 0, 0, 0);
    chk("directed_drained", q.size(), 0);

    // Stall with three beats in flight.
    start_out = n_out;
    out_ready = 1'b0;
    cyc(1, 10, 20, 1);
    cyc(1, 200, 100, 0);
    cyc(1, 77, 99, 1);
    repeat (5) cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_no_output", n_out - start_out, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) cyc(0, 0, 0, 0);
    chk("stall_released_count", n_out - start_out, 3);
    chk("stall_queue_empty", q.size(), 0);

    // Reset with two beats in flight.
    cyc(1, 5, 7, 1);
    cyc(1, 9, 9, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_out_p", out_p, 0);
    chk("midrst_in_ready", in_ready, 1);
`ifdef APPROX_MUL_STATS_EN
    chk("midrst_stat_count", stat_count, 0);
    chk("midrst_stat_err", stat_err, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    start_out = n_out;
    repeat (6) cyc(0, 0, 0, 0);
    chk("midrst_no_stale", n_out - start_out, 0);

    // Randomised traffic with random backpressure and dropped producer beats.
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom % 4) != 0;
      cyc(($urandom % 4) != 0, pick(), pick(), $urandom % 2);
    end

    // Bounded drain.
    out_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (q.size() == 0 && !out_valid) break;
      cyc(0, 0, 0, 0);
    end
    chk("final_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
